wrr_burst_arbiter: RTL and testbench

WRR_BURST_ARBITER -- requirements
Module: wrr_burst_arbiter

---
 rtl/wrr_pkg.sv | 20 ++
 rtl/wrr_burst_arbiter_rr_select.sv | 42 ++++
 rtl/wrr_burst_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_wrr_burst_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/wrr_pkg.sv
// -----------------------------------------------------------------------------
// wrr_pkg
// Shared definitions for the weighted round-robin burst arbiter:
//   - state_t      : arbiter FSM state (IDLE = no owner, OWN = grant held)
//   - N_DEF        : default number of requesters
//   - WW_DEF       : default width of each per-requester weight field
//   - TIMEOUT_DEF  : default watchdog limit in cycles (WRR_TIMEOUT_EN builds)
// -----------------------------------------------------------------------------
package wrr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam int N_DEF       = 4;
  localparam int WW_DEF      = 4;
  localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/wrr_burst_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Combinational rotating-priority picker. Scans req starting at ptr and
// wrapping modulo N; the first asserted request wins.
// Ports:
//   req      in  [N-1:0]   request vector
//   ptr      in  [IW-1:0]  index that has highest priority this scan
//   pick     out [N-1:0]   one-hot winner (all-zero when nothing requested)
//   pick_idx out [IW-1:0]  binary index of winner (0 when nothing requested)
//   any      out           at least one request is asserted
// -----------------------------------------------------------------------------
module rr_select
  import wrr_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] pick_idx,
  output logic          any
);

  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[IW'(idx)]) begin
        any             = 1'b1;
        pick[IW'(idx)]  = 1'b1;
        pick_idx        = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/wrr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// wrr_burst_arbiter
// Weighted round-robin arbiter with burst ownership. An owner keeps the grant
// for weight[owner] completed transfers (weight 0 counts as 1), or until it
// drops its request. A one-cycle idle bubble separates consecutive grants, and
// the next search starts just after the previous owner.
//
// Optional feature: define WRR_TIMEOUT_EN to add a watchdog that forces a
// release after TIMEOUT consecutive owned cycles without done, pulsing timeout.
// Without the macro the watchdog is absent and timeout is tied low.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst_n       in   synchronous active-low reset
//   req         in   [N-1:0] request levels, held until served
//   weight      in   [N*WW-1:0] packed weights, requester i at [i*WW +: WW]
//   done        in   one transfer completed this cycle by the current owner
//   grant       out  [N-1:0] registered one-hot grant
//   grant_valid out  grant is non-zero
//   grant_id    out  binary owner index, 0 when no owner
//   timeout     out  one-cycle pulse on watchdog-forced release
// -----------------------------------------------------------------------------
module wrr_burst_arbiter
  import wrr_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int WW      = WW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N*WW-1:0]      weight,
  input  logic                 done,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 timeout
);

  localparam int IW = $clog2(N);

  if (N < 2 || N > 16 || TIMEOUT < 1) begin : g_bad_param
    $error("wrr_burst_arbiter: N must be 2..16 and TIMEOUT >= 1");
  end

  function automatic logic [WW-1:0] load_credit(input logic [WW-1:0] w);
    return (w == '0) ? WW'(1) : w;
  endfunction

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] id);
    return (id == IW'(N - 1)) ? '0 : id + 1'b1;
  endfunction

  state_t        state, state_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [WW-1:0] credit, credit_n;
  logic [N-1:0]  grant_n;
  logic          grant_valid_n;
  logic [IW-1:0] grant_id_n;
  logic          rel;

  logic [WW-1:0] w [N];
  logic [N-1:0]  pick;
  logic [IW-1:0] pick_idx;
  logic          any;

  always_comb begin
    for (int i = 0; i < N; i++) w[i] = weight[i*WW +: WW];
  end

  rr_select #(
    .N  (N),
    .IW (IW)
  ) u_rr_select (
    .req      (req),
    .ptr      (ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (any)
  );

`ifdef WRR_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wdog, wdog_n;
  logic            timeout_q, timeout_n;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n       = state;
    ptr_n         = ptr;
    credit_n      = credit;
    grant_n       = grant;
    grant_valid_n = grant_valid;
    grant_id_n    = grant_id;
    rel           = 1'b0;
`ifdef WRR_TIMEOUT_EN
    wdog_n        = wdog;
    timeout_n     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (any) begin
          state_n       = OWN;
          grant_n       = pick;
          grant_valid_n = 1'b1;
          grant_id_n    = pick_idx;
          credit_n      = load_credit(w[pick_idx]);
`ifdef WRR_TIMEOUT_EN
          wdog_n        = '0;
`endif
        end
      end
      OWN: begin
        // Abort wins over every other release reason, so a dropped request
        // never produces a timeout pulse.
        if (!req[grant_id]) begin
          rel = 1'b1;
        end else if (done) begin
          if (credit <= WW'(1)) rel = 1'b1;
          else                  credit_n = credit - 1'b1;
`ifdef WRR_TIMEOUT_EN
          wdog_n = '0;
`endif
        end
`ifdef WRR_TIMEOUT_EN
        else if (wdog == WD_W'(TIMEOUT - 1)) begin
          rel       = 1'b1;
          timeout_n = 1'b1;
        end else begin
          wdog_n = wdog + 1'b1;
        end
`endif
        if (rel) begin
          state_n       = IDLE;
          grant_n       = '0;
          grant_valid_n = 1'b0;
          grant_id_n    = '0;
          credit_n      = '0;
          ptr_n         = next_ptr(grant_id);
`ifdef WRR_TIMEOUT_EN
          wdog_n        = '0;
`endif
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      credit      <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
`ifdef WRR_TIMEOUT_EN
      wdog        <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      credit      <= credit_n;
      grant       <= grant_n;
      grant_valid <= grant_valid_n;
      grant_id    <= grant_id_n;
`ifdef WRR_TIMEOUT_EN
      wdog        <= wdog_n;
      timeout_q   <= timeout_n;
`endif
    end
  end

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wrr_burst_arbiter
// Directed and randomized stimulus for wrr_burst_arbiter, compared every cycle
// against a behavioural model (owner index, remaining transfers, elapsed idle
// cycles) plus directed grant sequences.
// -----------------------------------------------------------------------------
module tb_wrr_burst_arbiter;

  localparam int N       = 4;
  localparam int WW      = 4;
  localparam int TIMEOUT = 8;
`ifdef WRR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N*WW-1:0]   weight;
  logic              done;
  logic [N-1:0]      grant;
  logic              grant_valid;
  logic [1:0]        grant_id;
  logic              timeout;

  int checks   = 0;
  int failures = 0;

  // model state: owner -1 means nobody holds the resource
  int m_owner = -1, m_left = 0, m_ptr = 0, m_idle = 0, m_to = 0;
  int n_owner, n_left, n_ptr, n_idle, n_to;

  always #5 clk = ~clk;

  wrr_burst_arbiter #(
    .N       (N),
    .WW      (WW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .weight      (weight),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout     (timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int wt(input int i);
    int v;
    v = int'(weight[i*WW +: WW]);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_next();
    int o;
    n_owner = m_owner; n_left = m_left; n_ptr = m_ptr; n_idle = m_idle; n_to = 0;
    if (!rst_n) begin
      n_owner = -1; n_left = 0; n_ptr = 0; n_idle = 0;
    end else if (m_owner < 0) begin
      if (req != '0) begin
        for (int k = 0; k < N; k++) begin
          if (req[(m_ptr + k) % N]) begin
            n_owner = (m_ptr + k) % N;
            break;
          end
        end
        n_left = wt(n_owner);
        n_idle = 0;
      end
    end else begin
      o = m_owner;
      if (!req[o]) begin
        n_owner = -1;
      end else if (done) begin
        n_left = m_left - 1;
        n_idle = 0;
        if (n_left == 0) n_owner = -1;
      end else begin
        n_idle = m_idle + 1;
        if (TO_EN && n_idle == TIMEOUT) begin
          n_owner = -1;
          n_to    = 1;
        end
      end
      if (n_owner < 0) n_ptr = (o + 1) % N;
    end
  endtask

  task automatic check_model();
    logic [N-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    check("model_grant", grant, eg);
    check("model_valid", grant_valid, (m_owner >= 0) ? 1 : 0);
    check("model_id", grant_id, (m_owner >= 0) ? m_owner : 0);
    check("model_timeout", timeout, m_to);
  endtask

  // one clock: model steps on the same edge as the DUT, outputs checked at negedge
  task automatic cycle();
    model_next();
    @(posedge clk);
    #1;
    m_owner = n_owner; m_left = n_left; m_ptr = n_ptr; m_idle = n_idle; m_to = n_to;
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  logic [N-1:0] seq031 [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                               4'b0000, 4'b1000, 4'b0000, 4'b0001};
  logic [N-1:0] seq032 [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010,
                               4'b0000, 4'b0001};

  initial begin
    int first_drop, to_cnt;
    rst_n = 1'b0; req = '0; weight = '0; done = 1'b0;
    @(negedge clk);

    // reset state
    cycle();
    cycle();
    check("reset_grant", grant, 0);
    check("reset_valid", grant_valid, 0);
    check("reset_id", grant_id, 0);
    check("reset_timeout", timeout, 0);

    // all requesting, weight 1, done every cycle: rotate with bubbles
    do_reset();
    req = 4'b1111; weight = 16'h1111; done = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cycle();
      check($sformatf("seq_rotate[%0d]", i), grant, seq031[i]);
    end

    // weight 3 vs weight 1
    do_reset();
    req = 4'b0011; weight = 16'h0013; done = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cycle();
      check($sformatf("seq_weighted[%0d]", i), grant, seq032[i]);
    end

    // abort after two transfers, then search restarts at requester 0
    do_reset();
    req = 4'b1000; weight = 16'h5000; done = 1'b0;
    cycle();
    check("abort_granted", grant, 4'b1000);
    done = 1'b1;
    cycle();
    cycle();
    check("abort_still_held", grant, 4'b1000);
    req = 4'b0000;
    cycle();
    check("abort_dropped", grant, 4'b0000);
    req = 4'b1111; done = 1'b0;
    cycle();
    check("abort_next_from_0", grant, 4'b0001);

    // weight 0 behaves as 1
    do_reset();
    req = 4'b0100; weight = 16'h0000; done = 1'b1;
    cycle();
    check("w0_granted", grant, 4'b0100);
    check("w0_id", grant_id, 2);
    cycle();
    check("w0_released", grant, 4'b0000);

    // reset during ownership of requester 3
    do_reset();
    req = 4'b1000; weight = 16'hF000; done = 1'b0;
    cycle();
    check("rst_owner3", grant_id, 3);
    req = 4'b1111;
    cycle();
    check("rst_nonowner_ignored", grant, 4'b1000);
    rst_n = 1'b0;
    cycle();
    check("rst_mid_grant", grant, 4'b0000);
    check("rst_mid_timeout", timeout, 0);
    rst_n = 1'b1;
    cycle();
    check("rst_next_grant", grant, 4'b0001);

    // watchdog: owner holds req, no done
    do_reset();
    req = 4'b0100; weight = 16'h0F00; done = 1'b0;
    first_drop = 0; to_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if (grant == '0 && first_drop == 0) first_drop = i;
      if (timeout) to_cnt++;
    end
    check("wdog_release_cycle", first_drop, TO_EN ? 9 : 0);
    check("wdog_pulse_count", to_cnt, TO_EN ? 1 : 0);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) weight = $urandom();
      rst_n = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 3) == 0) req = N'($urandom());
      else if (m_owner >= 0 && $urandom_range(0, 9) == 0) req[m_owner] = 1'b0;
      done = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
